// File: rtl/ad9854_par_writer.sv
// AD9854 parallel-port writer: snapshots the DDS tuning/control words on a CEN rise,
// writes them byte-by-byte with a WRB strobe, then pulses UDCLK and returns READY.
module ad9854_par_writer #(
    parameter int SETUP_CYC  = 2,
    parameter int WR_LOW_CYC = 2,
    parameter int HOLD_CYC   = 2,
    parameter int UD_CYC     = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CEN,
    input  logic [15:0] F1H,
    input  logic [31:0] F1L,
    input  logic [15:0] F2H,
    input  logic [31:0] F2L,
    input  logic [15:0] DFWH,
    input  logic [31:0] DFWL,
    input  logic [13:0] PTW1,
    input  logic [13:0] PTW2,
    input  logic [19:0] RAMPRATE,
    input  logic [2:0]  MODE,
    input  logic        TRAIANGLE,
    input  logic        PLLEN,
    input  logic [4:0]  CLKMUILT,
    input  logic        PLLRANGE,
    input  logic        OSK,
    output logic [5:0]  DDS_A,
    output logic [7:0]  DDS_D,
    output logic        DDS_WRB,
    output logic        DDS_UDCLK,
    output logic        BUSY,
    output logic        READY
);

    localparam int NB     = 29;
    localparam int MAX_A  = (SETUP_CYC > WR_LOW_CYC) ? SETUP_CYC : WR_LOW_CYC;
    localparam int MAX_B  = (HOLD_CYC > UD_CYC) ? HOLD_CYC : UD_CYC;
    localparam int MAXP   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] W_LD = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] U_LD = CW'(UD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        UPDATE,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [4:0]        idx_reg, idx_next;
    logic              cen_q_reg;
    logic [8*NB-1:0]   shadow_reg;
    logic [8*NB-1:0]   image;
    logic [5:0]        a_reg, a_next;
    logic [7:0]        d_reg, d_next;
    logic              wrb_reg, wrb_next;
    logic              ud_reg, ud_next;
    logic              busy_reg, busy_next;
    logic              ready_reg, ready_next;
    logic              start;
    logic [47:0]       ftw1, ftw2, dfw;
    logic [23:0]       ramp;

    assign ftw1 = {F1H, F1L};
    assign ftw2 = {F2H, F2L};
    assign dfw  = {DFWH, DFWL};
    assign ramp = {4'b0000, RAMPRATE};

    // Byte image in write order, byte i at image[8*i +: 8]; multi-byte words go MSB first.
    assign image[7:0]   = 8'h00;
    assign image[15:8]  = {1'b0, PLLRANGE, ~PLLEN, CLKMUILT};
    assign image[23:16] = {2'b00, TRAIANGLE, 1'b0, MODE, 1'b0};
    assign image[31:24] = {2'b00, OSK, 5'b00000};
    assign image[39:32] = {2'b00, PTW1[13:8]};
    assign image[47:40] = PTW1[7:0];
    assign image[55:48] = {2'b00, PTW2[13:8]};
    assign image[63:56] = PTW2[7:0];

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_words48
            assign image[8*(8+gi)  +: 8] = ftw1[47-8*gi -: 8];
            assign image[8*(14+gi) +: 8] = ftw2[47-8*gi -: 8];
            assign image[8*(20+gi) +: 8] = dfw[47-8*gi -: 8];
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_ramp
            assign image[8*(26+gi) +: 8] = ramp[23-8*gi -: 8];
        end
    endgenerate

    // Control registers sit at 0x1D-0x20, then 0x00-0x15, skipping the update clock to 0x1A.
    function automatic logic [5:0] addr_of(input logic [4:0] idx);
        if (idx < 5'd4)
            addr_of = 6'h1D + {4'b0000, idx[1:0]};
        else if (idx < 5'd26)
            addr_of = {1'b0, idx - 5'd4};
        else
            addr_of = {1'b0, idx};
    endfunction

    assign start = CEN && !cen_q_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                    cnt_next   = S_LD;
                    idx_next   = 5'd0;
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = STROBE;
                    cnt_next   = W_LD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                    cnt_next   = H_LD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (idx_reg < 5'd28) begin
                    state_next = SETUP;
                    cnt_next   = S_LD;
                    idx_next   = idx_reg + 5'd1;
                end else begin
                    state_next = UPDATE;
                    cnt_next   = U_LD;
                end
            end
            UPDATE: begin
                if (cnt_reg == '0)
                    state_next = DONE;
                else
                    cnt_next = cnt_reg - 1'b1;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        a_next     = 6'd0;
        d_next     = 8'd0;
        wrb_next   = (state_next != STROBE);
        ud_next    = (state_next == UPDATE);
        busy_next  = (state_next != IDLE);
        ready_next = (state_next == DONE);
        if (state_next != IDLE) begin
            a_next = addr_of(idx_next);
            d_next = shadow_reg[{idx_next, 3'b000} +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= 5'd0;
            cen_q_reg  <= 1'b0;
            shadow_reg <= '0;
            a_reg      <= 6'd0;
            d_reg      <= 8'd0;
            wrb_reg    <= 1'b1;
            ud_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            cen_q_reg <= CEN;
            if (state_reg == IDLE && start)
                shadow_reg <= image;
            a_reg     <= a_next;
            d_reg     <= d_next;
            wrb_reg   <= wrb_next;
            ud_reg    <= ud_next;
            busy_reg  <= busy_next;
            ready_reg <= ready_next;
        end
    end

    assign DDS_A     = a_reg;
    assign DDS_D     = d_reg;
    assign DDS_WRB   = wrb_reg;
    assign DDS_UDCLK = ud_reg;
    assign BUSY      = busy_reg;
    assign READY     = ready_reg;

endmodule

// File: tb/tb_ad9854_par_writer.sv
// Directed bench for ad9854_par_writer: default-parameter DUT plus a short-timing DUT
// sharing the same stimulus; bus writes are captured by a negedge monitor.
module tb_ad9854_par_writer;

    logic        CLK = 1'b0;
    logic        RST, CEN;
    logic [15:0] F1H, F2H, DFWH;
    logic [31:0] F1L, F2L, DFWL;
    logic [13:0] PTW1, PTW2;
    logic [19:0] RAMPRATE;
    logic [2:0]  MODE;
    logic        TRAIANGLE, PLLEN, PLLRANGE, OSK;
    logic [4:0]  CLKMUILT;

    logic [5:0]  DDS_A, a2;
    logic [7:0]  DDS_D, d2;
    logic        DDS_WRB, wrb2, DDS_UDCLK, ud2, BUSY, busy2, READY, ready2;

    always #5 CLK = ~CLK;

    ad9854_par_writer dut (
        .CLK(CLK), .RST(RST), .CEN(CEN),
        .F1H(F1H), .F1L(F1L), .F2H(F2H), .F2L(F2L), .DFWH(DFWH), .DFWL(DFWL),
        .PTW1(PTW1), .PTW2(PTW2), .RAMPRATE(RAMPRATE), .MODE(MODE),
        .TRAIANGLE(TRAIANGLE), .PLLEN(PLLEN), .CLKMUILT(CLKMUILT),
        .PLLRANGE(PLLRANGE), .OSK(OSK),
        .DDS_A(DDS_A), .DDS_D(DDS_D), .DDS_WRB(DDS_WRB), .DDS_UDCLK(DDS_UDCLK),
        .BUSY(BUSY), .READY(READY)
    );

    ad9854_par_writer #(.SETUP_CYC(1), .WR_LOW_CYC(3), .HOLD_CYC(1), .UD_CYC(1)) dut2 (
        .CLK(CLK), .RST(RST), .CEN(CEN),
        .F1H(F1H), .F1L(F1L), .F2H(F2H), .F2L(F2L), .DFWH(DFWH), .DFWL(DFWL),
        .PTW1(PTW1), .PTW2(PTW2), .RAMPRATE(RAMPRATE), .MODE(MODE),
        .TRAIANGLE(TRAIANGLE), .PLLEN(PLLEN), .CLKMUILT(CLKMUILT),
        .PLLRANGE(PLLRANGE), .OSK(OSK),
        .DDS_A(a2), .DDS_D(d2), .DDS_WRB(wrb2), .DDS_UDCLK(ud2),
        .BUSY(busy2), .READY(ready2)
    );

    logic [7:0] exp1 [0:28] = '{8'h00, 8'h6A, 8'h26, 8'h20, 8'h3F, 8'hFF, 8'h12, 8'h34,
                                8'h12, 8'h34, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                                8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04,
                                8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54,
                                8'h0A, 8'hBC, 8'hDE};
    logic [7:0] exp2 [0:28] = '{8'h00, 8'h04, 8'h08, 8'h00, 8'h00, 8'h01, 8'h2A, 8'hBC,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                8'h13, 8'h57, 8'h24, 8'h68, 8'hAC, 8'hE0,
                                8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
                                8'h0F, 8'hFF, 8'hFF};
    logic [5:0] exp_a [0:28] = '{6'h1D, 6'h1E, 6'h1F, 6'h20, 6'h00, 6'h01, 6'h02, 6'h03,
                                 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15,
                                 6'h1A, 6'h1B, 6'h1C};

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // monitor state (written only by the monitor process)
    logic [5:0] wa [0:255];
    logic [7:0] wd [0:255];
    int         wl [0:255];
    int         wl2 [0:255];
    int nw = 0, n2 = 0, lw = 0, lw2 = 0;
    int ud_hi = 0, ud_first = 0, ready_cnt = 0, ready_cyc = 0, ready2_cyc = 0;
    int unstable = 0, overlap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        logic prev_wrb, prev_ud, prev_wrb2;
        prev_wrb = 1'b1; prev_ud = 1'b0; prev_wrb2 = 1'b1;
        forever begin
            @(negedge CLK);
            if (DDS_WRB === 1'b0) begin
                if (prev_wrb) begin
                    wa[nw] = DDS_A; wd[nw] = DDS_D; nw++; lw = 1;
                end else begin
                    lw++;
                    if (DDS_A !== wa[nw-1] || DDS_D !== wd[nw-1]) unstable++;
                end
            end else if (!prev_wrb) begin
                wl[nw-1] = lw;
            end
            if (DDS_UDCLK === 1'b1) begin
                if (!prev_ud) ud_first = cyc;
                ud_hi++;
                if (DDS_WRB !== 1'b1) overlap++;
            end
            if (READY === 1'b1) begin
                ready_cnt++; ready_cyc = cyc;
            end
            if (wrb2 === 1'b0) begin
                if (prev_wrb2) begin n2++; lw2 = 1; end
                else lw2++;
            end else if (!prev_wrb2) begin
                wl2[n2-1] = lw2;
            end
            if (ready2 === 1'b1) ready2_cyc = cyc;
            prev_wrb  = (DDS_WRB !== 1'b0);
            prev_ud   = (DDS_UDCLK === 1'b1);
            prev_wrb2 = (wrb2 !== 1'b0);
        end
    end

    task automatic set_vec(input int which);
        if (which == 1) begin
            PLLEN = 0; PLLRANGE = 1; CLKMUILT = 5'd10; MODE = 3'b011; TRAIANGLE = 1; OSK = 1;
            PTW1 = 14'h3FFF; PTW2 = 14'h1234; F1H = 16'h1234; F1L = 32'h89ABCDEF;
            F2H = 16'hA5A5; F2L = 32'h01020304; DFWH = 16'hFEDC; DFWL = 32'hBA987654;
            RAMPRATE = 20'hABCDE;
        end else begin
            PLLEN = 1; PLLRANGE = 0; CLKMUILT = 5'd4; MODE = 3'b100; TRAIANGLE = 0; OSK = 0;
            PTW1 = 14'h0001; PTW2 = 14'h2ABC; F1H = 16'h0000; F1L = 32'h00000001;
            F2H = 16'h1357; F2L = 32'h2468ACE0; DFWH = 16'h0F0F; DFWL = 32'hF0F0F0F0;
            RAMPRATE = 20'hFFFFF;
        end
    endtask

    task automatic run_transfer(input int which, input bit disturb, input bit chk2);
        int base, udb, rb, b2, k;
        bit got;
        logic [7:0] e;
        base = nw; udb = ud_hi; rb = ready_cnt; b2 = n2; got = 0;
        @(negedge CLK); #1;
        CEN = 1'b1;
        k = cyc + 1;
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge CLK); #1;
            if (disturb && t == 40) begin F2L = 32'hDEADBEEF; CEN = 1'b0; end
            if (disturb && t == 46) CEN = 1'b1;
            if (ready_cnt != rb) got = 1;
        end
        check($sformatf("t%0d_ready_seen", which), got, 1);
        check($sformatf("t%0d_ready_lat", which), ready_cyc - k, 178);
        check($sformatf("t%0d_busy_at_ready", which), BUSY, 1);
        check($sformatf("t%0d_ud_cycles", which), ud_hi - udb, 4);
        check($sformatf("t%0d_ud_start", which), ud_first - k, 174);
        @(negedge CLK); #1;
        check($sformatf("t%0d_ready_pulse", which), READY, 0);
        check($sformatf("t%0d_busy_off", which), BUSY, 0);
        check($sformatf("t%0d_a_idle", which), DDS_A, 0);
        check($sformatf("t%0d_d_idle", which), DDS_D, 0);
        check($sformatf("t%0d_nbytes", which), nw - base, 29);
        for (int i = 0; i < 29; i++) begin
            e = (which == 1) ? exp1[i] : exp2[i];
            check($sformatf("t%0d_addr%0d", which, i), wa[base+i], exp_a[i]);
            check($sformatf("t%0d_data%0d", which, i), wd[base+i], e);
            check($sformatf("t%0d_wlow%0d", which, i), wl[base+i], 2);
        end
        if (chk2) begin
            check($sformatf("t%0d_p2_ready_lat", which), ready2_cyc - k, 146);
            check($sformatf("t%0d_p2_nbytes", which), n2 - b2, 29);
            for (int i = 0; i < 29; i++)
                check($sformatf("t%0d_p2_wlow%0d", which, i), wl2[b2+i], 3);
        end
        repeat (30) @(negedge CLK);
        #1;
        check($sformatf("t%0d_one_xfer", which), nw - base, 29);
        CEN = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
    endtask

    initial begin
        int base, udb, rb;
        bit hit;
        RST = 1'b1; CEN = 1'b0;
        set_vec(1);
        repeat (3) @(negedge CLK);
        #1;
        check("rst_a", DDS_A, 0);
        check("rst_d", DDS_D, 0);
        check("rst_wrb", DDS_WRB, 1);
        check("rst_ud", DDS_UDCLK, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ready", READY, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;

        run_transfer(1, 1'b0, 1'b1);
        set_vec(2);
        run_transfer(2, 1'b1, 1'b0);

        // abort during the strobe of byte index 10
        set_vec(1);
        base = nw; udb = ud_hi; rb = ready_cnt; hit = 0;
        CEN = 1'b1;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge CLK); #1;
            if (nw - base >= 11) hit = 1;
        end
        check("abort_reached", hit, 1);
        check("abort_in_strobe", DDS_WRB, 0);
        RST = 1'b1;
        @(negedge CLK); #1;
        check("abort_wrb", DDS_WRB, 1);
        check("abort_busy", BUSY, 0);
        check("abort_a", DDS_A, 0);
        check("abort_d", DDS_D, 0);
        RST = 1'b0; CEN = 1'b0;
        repeat (250) @(negedge CLK);
        #1;
        check("abort_no_ud", ud_hi - udb, 0);
        check("abort_no_ready", ready_cnt - rb, 0);
        check("abort_nbytes", nw - base, 11);

        run_transfer(1, 1'b0, 1'b1);

        check("ad_stable_in_strobe", unstable, 0);
        check("ud_wrb_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
